// File: rtl/user_id_serial_reader.sv
// Reads the tie-cell encoded project ID: samples it twice to confirm it is stable,
// latches it, and streams it MSB-first followed by an even-parity bit.
// Ports:
//   wb_clk_i, wb_rst_i   clock and synchronous active-high reset
//   id_bits_i            raw tie-cell outputs
//   rd_req_i             read request, accepted only when idle
//   busy_o               high whenever a read is in progress
//   id_value_o/valid_o   last good ID and its valid flag
//   id_err_o             stability failure flag
//   sdo_o/bit_stb_o      serial data and first-clock-of-bit strobe
//   frame_o              high across all data and parity bits
//   done_o               one-cycle pulse at the end of every read
module user_id_serial_reader #(
    parameter int unsigned ID_WIDTH  = 32,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [ID_WIDTH-1:0] id_bits_i,
    input  logic                rd_req_i,
    output logic                busy_o,
    output logic [ID_WIDTH-1:0] id_value_o,
    output logic                id_valid_o,
    output logic                id_err_o,
    output logic                sdo_o,
    output logic                bit_stb_o,
    output logic                frame_o,
    output logic                done_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(ID_WIDTH + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMP_A = 3'd1,
        SAMP_B = 3'd2,
        SHIFT  = 3'd3,
        PARITY = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] samp_a_q, samp_a_d;
    logic [ID_WIDTH-1:0] shift_q, shift_d;
    logic [ID_WIDTH-1:0] id_value_q, id_value_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic                parity_q, parity_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                sdo_q, sdo_d;
    logic                stb_q, stb_d;
    logic                frame_q, frame_d;
    logic                done_q, done_d;

    // State, datapath and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            samp_a_q   <= '0;
            shift_q    <= '0;
            id_value_q <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            retry_q    <= '0;
            parity_q   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            sdo_q      <= 1'b0;
            stb_q      <= 1'b0;
            frame_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_a_q   <= samp_a_d;
            shift_q    <= shift_d;
            id_value_q <= id_value_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            retry_q    <= retry_d;
            parity_q   <= parity_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            sdo_q      <= sdo_d;
            stb_q      <= stb_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        samp_a_d   = samp_a_q;
        shift_d    = shift_q;
        id_value_d = id_value_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        retry_d    = retry_q;
        parity_d   = parity_q;
        valid_d    = valid_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (rd_req_i) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    state_d = SAMP_A;
                end
            end
            SAMP_A: begin
                samp_a_d = id_bits_i;
                state_d  = SAMP_B;
            end
            SAMP_B: begin
                // Second sample is compared live against the first
                if (samp_a_q == id_bits_i) begin
                    id_value_d = id_bits_i;
                    valid_d    = 1'b1;
                    shift_d    = id_bits_i;
                    parity_d   = ^id_bits_i;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = SHIFT;
                end else begin
                    retry_d = retry_q + RTY_W'(1);
                    if (retry_d == RTY_W'(MAX_RETRY)) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        state_d = SAMP_A;
                    end
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    shift_d   = {shift_q[ID_WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == BIT_W'(ID_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            PARITY: begin
                if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt_d = '0;
                    state_d   = DONE;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        frame_d = (state_d == SHIFT) || (state_d == PARITY);
        stb_d   = frame_d && (div_cnt_d == '0);
        done_d  = (state_d == DONE) || (state_d == ERROR);
        if (state_d == SHIFT) begin
            sdo_d = shift_d[ID_WIDTH-1];
        end else if (state_d == PARITY) begin
            sdo_d = parity_d;
        end else begin
            sdo_d = 1'b0;
        end
    end

    assign busy_o     = busy_q;
    assign id_value_o = id_value_q;
    assign id_valid_o = valid_q;
    assign id_err_o   = err_q;
    assign sdo_o      = sdo_q;
    assign bit_stb_o  = stb_q;
    assign frame_o    = frame_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_user_id_serial_reader.sv
module tb_user_id_serial_reader;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] id_bits = '0;

    logic         rd_req4, rd_req1;
    logic         busy4, valid4, err4, sdo4, stb4, frame4, done4;
    logic         busy1, valid1, err1, sdo1, stb1, frame1, done1;
    logic [W-1:0] value4, value1;

    logic         o_busy, o_valid, o_err, o_sdo, o_stb, o_frame, o_done;
    logic [W-1:0] o_value;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rd_req4 = rd_req & ~sel;
    assign rd_req1 = rd_req & sel;

    user_id_serial_reader #(.ID_WIDTH(W), .CLK_DIV(4), .MAX_RETRY(3)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .id_bits_i(id_bits), .rd_req_i(rd_req4),
        .busy_o(busy4), .id_value_o(value4), .id_valid_o(valid4), .id_err_o(err4),
        .sdo_o(sdo4), .bit_stb_o(stb4), .frame_o(frame4), .done_o(done4)
    );

    user_id_serial_reader #(.ID_WIDTH(W), .CLK_DIV(1), .MAX_RETRY(3)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .id_bits_i(id_bits), .rd_req_i(rd_req1),
        .busy_o(busy1), .id_value_o(value1), .id_valid_o(valid1), .id_err_o(err1),
        .sdo_o(sdo1), .bit_stb_o(stb1), .frame_o(frame1), .done_o(done1)
    );

    assign o_busy  = sel ? busy1  : busy4;
    assign o_valid = sel ? valid1 : valid4;
    assign o_err   = sel ? err1   : err4;
    assign o_sdo   = sel ? sdo1   : sdo4;
    assign o_stb   = sel ? stb1   : stb4;
    assign o_frame = sel ? frame1 : frame4;
    assign o_done  = sel ? done1  : done4;
    assign o_value = sel ? value1 : value4;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Even parity by counting ones
    function automatic logic ref_parity(input logic [W-1:0] v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += int'(v[i]);
        return ((ones % 2) == 1);
    endfunction

    // Request a read; returns at the clock where id_valid_o should have risen.
    task automatic start_read(input logic [W-1:0] id, input bit hold);
        id_bits = id;
        rd_req  = 1'b1;
        tick();
        rd_req = hold;
        chk("accept_busy_valid", 32'({o_busy, o_valid}), 32'b10);
        tick();
        chk("sampb_valid", 32'({o_valid, o_frame}), 32'b00);
        tick();
        chk("valid_latency", 32'({o_valid, o_err}), 32'b10);
        chk("id_value", o_value, id);
    endtask

    // Expected serial frame: ID bits MSB first then parity, each held div clocks.
    task automatic check_frame(input logic [W-1:0] id, input int div, input bit poke, input bit hold);
        logic seq[$];
        int   n;
        int   stb_seen;
        for (int i = W - 1; i >= 0; i--) seq.push_back(id[i]);
        seq.push_back(ref_parity(id));
        n = (W + 1) * div;
        stb_seen = 0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("frame_fss[%0d]", k), 32'({o_frame, o_stb, o_sdo, o_done}),
                32'({1'b1, ((k % div) == 0), seq[k / div], 1'b0}));
            if (o_stb) stb_seen++;
            rd_req = hold || (poke && (k == 5 || k == n - 2));
            tick();
        end
        chk("stb_count", 32'(stb_seen), 32'(W + 1));
        chk("done_pulse", 32'({o_frame, o_stb, o_sdo, o_done}), 32'b0001);
    endtask

    initial begin
        logic [W-1:0] id;
        logic [W-1:0] good;

        tick();
        tick();
        chk("reset_outs", 32'({o_busy, o_valid, o_err, o_sdo, o_stb, o_frame, o_done}), 32'd0);
        chk("reset_value", o_value, 32'd0);
        rst = 1'b0;
        tick();

        // Directed pattern, CLK_DIV=4
        start_read(32'hA5C3_0F1E, 1'b0);
        check_frame(32'hA5C3_0F1E, 4, 1'b0, 1'b0);
        tick();
        chk("post_idle", 32'({o_busy, o_done, o_valid}), 32'b001);

        // Single set bit, CLK_DIV=1: parity 1
        sel = 1'b1;
        tick();
        start_read(32'h0000_0001, 1'b0);
        check_frame(32'h0000_0001, 1, 1'b0, 1'b0);
        tick();
        chk("post_idle_div1", 32'({o_busy, o_done}), 32'b00);

        // Random IDs on both instances
        for (int r = 0; r < 3; r++) begin
            sel = (r == 2);
            tick();
            id = $urandom;
            start_read(id, 1'b0);
            check_frame(id, sel ? 1 : 4, 1'b0, 1'b0);
            tick();
        end

        // Unstable ID: error after three mismatching sample pairs
        sel = 1'b0;
        tick();
        good = $urandom;
        start_read(good, 1'b0);
        check_frame(good, 4, 1'b0, 1'b0);
        tick();
        id_bits = $urandom;
        rd_req  = 1'b1;
        tick();
        rd_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("err_wait[%0d]", c), 32'({o_frame, o_done, o_err, o_busy, o_valid}), 32'b00010);
            id_bits[0] = ~id_bits[0];
            tick();
        end
        chk("err_flags", 32'({o_err, o_valid, o_done, o_busy, o_frame}), 32'b10110);
        chk("err_keeps_value", o_value, good);
        tick();
        chk("err_sticky", 32'({o_err, o_valid, o_done, o_busy}), 32'b1000);

        // One mismatch, then stable DEADBEEF
        id = 32'hDEAD_BEEF ^ 32'h0000_0100;
        id_bits = id;
        rd_req  = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        id_bits = 32'hDEAD_BEEF;
        tick();
        chk("retry_pending", 32'({o_valid, o_busy, o_err}), 32'b010);
        tick();
        tick();
        chk("retry_valid", 32'({o_valid, o_err}), 32'b10);
        chk("retry_value", o_value, 32'hDEAD_BEEF);
        check_frame(32'hDEAD_BEEF, 4, 1'b0, 1'b0);
        tick();

        // Requests during SHIFT and PARITY are ignored
        id = $urandom;
        start_read(id, 1'b0);
        check_frame(id, 4, 1'b1, 1'b0);
        rd_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("no_queued[%0d]", c), 32'({o_busy, o_frame, o_valid}), 32'b001);
        end

        // Held request: back-to-back reads with one idle cycle
        id = $urandom;
        start_read(id, 1'b1);
        check_frame(id, 4, 1'b0, 1'b1);
        tick();
        chk("b2b_idle", 32'({o_busy, o_valid, o_done}), 32'b010);
        good = $urandom;
        start_read(good, 1'b0);
        check_frame(good, 4, 1'b0, 1'b0);
        tick();

        // Reset during SHIFT at bit 10, then a normal read
        id = $urandom;
        start_read(id, 1'b0);
        for (int c = 0; c < 10 * 4 + 1; c++) tick();
        chk("pre_rst_frame", 32'({o_frame, o_busy}), 32'b11);
        rst = 1'b1;
        tick();
        chk("mid_rst_outs", 32'({o_busy, o_valid, o_err, o_sdo, o_stb, o_frame, o_done}), 32'd0);
        chk("mid_rst_value", o_value, 32'd0);
        rst = 1'b0;
        tick();
        id = $urandom;
        start_read(id, 1'b0);
        check_frame(id, 4, 1'b0, 1'b0);
        tick();
        chk("final_idle", 32'({o_busy, o_valid, o_err}), 32'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
